// File: rtl/mem_bus_arbiter_if.sv
// Handshake and bus signals between the two masters, the arbiter and the memory side.
// The arbiter connects through the slave modport; masters and the memory model use master.
interface mem_bus_arbiter_if;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 8;

    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [MASK_W-1:0] mask0, mask1;
    logic              rw0, rw1;
    logic              gnt0, gnt1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [MASK_W-1:0] bus_mask;
    logic              bus_rw;
    logic              bus_en;
    logic [DATA_W-1:0] bus_rdata;
    logic              err;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, mask0, mask1, rw0, rw1, bus_rdata,
        output gnt0, gnt1, ack0, ack1, rdata0, rdata1,
               bus_addr, bus_wdata, bus_mask, bus_rw, bus_en, err
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, mask0, mask1, rw0, rw1, bus_rdata,
        input  gnt0, gnt1, ack0, ack1, rdata0, rdata1,
               bus_addr, bus_wdata, bus_mask, bus_rw, bus_en, err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between M0 (CPU) and M1 (DMA/IO).
// Define MEM_ARB_BIOS_WP_EN to reject writes into the BIOS ROM window with an err pulse.
module mem_bus_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state, state_nxt;
    logic              owner, owner_nxt;
    logic              prio, prio_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              winner_c;
    logic              busy_nxt;
    logic              capture_c;
    logic              err_nxt;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic [MASK_W-1:0] sel_mask_c;
    logic              sel_rw_c;
`ifdef MEM_ARB_BIOS_WP_EN
    localparam logic [47:0] BIOS_HI = 48'hFFFF_FFFF_FFFF;
    logic              reject, reject_nxt;
    logic              bios_hit_c;
`endif

    // Next-state, arbitration and next values of the registered outputs
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        prio_nxt  = prio;
        cnt_nxt   = cnt;
        winner_c  = (bus.req0 && bus.req1) ? prio : bus.req1;
`ifdef MEM_ARB_BIOS_WP_EN
        reject_nxt = reject;
        bios_hit_c = winner_c ? (bus.rw1 && (bus.addr1[63:16] == BIOS_HI))
                              : (bus.rw0 && (bus.addr0[63:16] == BIOS_HI));
`endif
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_nxt = winner_c;
                    state_nxt = ISSUE;
`ifdef MEM_ARB_BIOS_WP_EN
                    reject_nxt = bios_hit_c;
                    if (bios_hit_c) state_nxt = ACK;
`endif
                end
            end
            ISSUE: begin
                cnt_nxt   = CNT_W'(MEM_LAT - 1);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_nxt = ACK;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            ACK: begin
                prio_nxt  = ~owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        sel_addr_c  = owner_nxt ? bus.addr1  : bus.addr0;
        sel_wdata_c = owner_nxt ? bus.wdata1 : bus.wdata0;
        sel_mask_c  = owner_nxt ? bus.mask1  : bus.mask0;
        sel_rw_c    = owner_nxt ? bus.rw1    : bus.rw0;
        busy_nxt    = (state_nxt != IDLE);
        // Memory data is valid in the last WAIT cycle so rdata is ready alongside ack
        capture_c   = (state == WAIT) && (state_nxt == ACK) && !sel_rw_c;
`ifdef MEM_ARB_BIOS_WP_EN
        err_nxt     = (state_nxt == ACK) && reject_nxt;
`else
        err_nxt     = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            prio  <= 1'b0;
            cnt   <= '0;
`ifdef MEM_ARB_BIOS_WP_EN
            reject <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            prio  <= prio_nxt;
            cnt   <= cnt_nxt;
`ifdef MEM_ARB_BIOS_WP_EN
            reject <= reject_nxt;
`endif
        end
    end

    // Outputs registered from next-state values so they line up with the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.bus_en    <= 1'b0;
            bus.err       <= 1'b0;
            bus.rdata0    <= '0;
            bus.rdata1    <= '0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_mask  <= '0;
            bus.bus_rw    <= 1'b0;
        end else begin
            bus.gnt0   <= busy_nxt && !owner_nxt;
            bus.gnt1   <= busy_nxt && owner_nxt;
            bus.ack0   <= (state_nxt == ACK) && !owner_nxt;
            bus.ack1   <= (state_nxt == ACK) && owner_nxt;
            bus.bus_en <= (state_nxt == ISSUE);
            bus.err    <= err_nxt;
            if (busy_nxt) begin
                bus.bus_addr  <= sel_addr_c;
                bus.bus_wdata <= sel_wdata_c;
                bus.bus_mask  <= sel_mask_c;
                bus.bus_rw    <= sel_rw_c;
            end
            if (capture_c) begin
                if (owner) bus.rdata1 <= bus.bus_rdata;
                else       bus.rdata0 <= bus.bus_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=4.
// BIOS-window expectations follow whether MEM_ARB_BIOS_WP_EN is defined.
module tb_mem_bus_arbiter;
    logic clk;
    logic rst1, rst4;
    int   total;
    int   bad;

    mem_bus_arbiter_if if1();
    mem_bus_arbiter_if if4();

    mem_bus_arbiter #(.MEM_LAT(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(if1));
    mem_bus_arbiter #(.MEM_LAT(4)) u_dut4 (.clk(clk), .reset(rst4), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst4 = 1'b1;
        if1.req0 = 0; if1.req1 = 0; if1.rw0 = 0; if1.rw1 = 0;
        if1.addr0 = '0; if1.addr1 = '0; if1.wdata0 = '0; if1.wdata1 = '0;
        if1.mask0 = '0; if1.mask1 = '0; if1.bus_rdata = '0;
        if4.req0 = 0; if4.req1 = 0; if4.rw0 = 0; if4.rw1 = 0;
        if4.addr0 = '0; if4.addr1 = '0; if4.wdata0 = '0; if4.wdata1 = '0;
        if4.mask0 = '0; if4.mask1 = '0; if4.bus_rdata = '0;
        repeat (3) tick();
        total++; if ({if1.gnt0, if1.gnt1, if1.ack0, if1.ack1, if1.bus_en, if1.err, if1.bus_rw} !== 7'b0) begin bad++; $display("FAIL reset_ctrl1 got=%b exp=0", {if1.gnt0, if1.gnt1, if1.ack0, if1.ack1, if1.bus_en, if1.err, if1.bus_rw}); end
        total++; if ({if1.rdata0, if1.rdata1} !== 128'h0) begin bad++; $display("FAIL reset_rdata1 got=%h exp=0", {if1.rdata0, if1.rdata1}); end
        total++; if ({if1.bus_addr, if1.bus_wdata, if1.bus_mask} !== 136'h0) begin bad++; $display("FAIL reset_bus1 got=%h exp=0", {if1.bus_addr, if1.bus_wdata, if1.bus_mask}); end
        total++; if ({if4.gnt0, if4.gnt1, if4.ack0, if4.ack1, if4.bus_en, if4.err, if4.bus_rw} !== 7'b0) begin bad++; $display("FAIL reset_ctrl4 got=%b exp=0", {if4.gnt0, if4.gnt1, if4.ack0, if4.ack1, if4.bus_en, if4.err, if4.bus_rw}); end
        rst1 = 1'b0; rst4 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if ({if1.bus_en, if1.gnt0, if1.gnt1} !== 3'b0) begin bad++; $display("FAIL idle_no_req got=%b exp=000", {if1.bus_en, if1.gnt0, if1.gnt1}); end
        end
    endtask

    task automatic test_single_read();
        if1.req0 = 1; if1.rw0 = 0; if1.addr0 = 64'h100; if1.mask0 = 8'hFF;
        if1.bus_rdata = 64'hDEAD_BEEF;
        tick();
        total++; if (if1.bus_en !== 1'b1) begin bad++; $display("FAIL read_bus_en got=%b exp=1", if1.bus_en); end
        total++; if (if1.bus_addr !== 64'h100) begin bad++; $display("FAIL read_bus_addr got=%h exp=100", if1.bus_addr); end
        total++; if ({if1.gnt0, if1.gnt1, if1.bus_rw} !== 3'b100) begin bad++; $display("FAIL read_gnt_rw got=%b exp=100", {if1.gnt0, if1.gnt1, if1.bus_rw}); end
        tick();
        total++; if ({if1.bus_en, if1.ack0, if1.gnt0} !== 3'b001) begin bad++; $display("FAIL read_wait got=%b exp=001", {if1.bus_en, if1.ack0, if1.gnt0}); end
        tick();
        total++; if ({if1.ack0, if1.ack1, if1.gnt0} !== 3'b101) begin bad++; $display("FAIL read_ack got=%b exp=101", {if1.ack0, if1.ack1, if1.gnt0}); end
        total++; if (if1.rdata0 !== 64'hDEAD_BEEF) begin bad++; $display("FAIL read_rdata0 got=%h exp=deadbeef", if1.rdata0); end
        if1.req0 = 0;
        tick();
        total++; if ({if1.ack0, if1.gnt0, if1.bus_en} !== 3'b000) begin bad++; $display("FAIL read_after got=%b exp=000", {if1.ack0, if1.gnt0, if1.bus_en}); end
        total++; if (if1.bus_addr !== 64'h100) begin bad++; $display("FAIL read_bus_hold got=%h exp=100", if1.bus_addr); end
    endtask

    task automatic test_contention();
        int order [4];
        int exp_order [4];
        int n;
        int last_cyc;
        logic overlap;
        exp_order = '{0, 1, 0, 1};
        order = '{9, 9, 9, 9};
        n = 0; last_cyc = -1; overlap = 1'b0;
        rst1 = 1'b1;
        if1.req0 = 1; if1.req1 = 1; if1.rw0 = 0; if1.rw1 = 0;
        if1.addr0 = 64'h10; if1.addr1 = 64'h20; if1.bus_rdata = 64'hA5;
        tick(); tick();
        rst1 = 1'b0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            tick();
            if ((if1.gnt0 && if1.gnt1) || (if1.ack0 && if1.ack1)) overlap = 1'b1;
            if (if1.ack0)      begin order[n] = 0; n++; last_cyc = c; end
            else if (if1.ack1) begin order[n] = 1; n++; last_cyc = c; end
        end
        if1.req0 = 0; if1.req1 = 0;
        tick();
        total++; if (n !== 4) begin bad++; $display("FAIL cont_count got=%0d exp=4", n); end
        total++; if (overlap !== 1'b0) begin bad++; $display("FAIL cont_overlap got=%b exp=0", overlap); end
        for (int i = 0; i < 4; i++) begin
            total++; if (order[i] !== exp_order[i]) begin bad++; $display("FAIL cont_order%0d got=M%0d exp=M%0d", i, order[i], exp_order[i]); end
        end
        total++; if (last_cyc !== 15) begin bad++; $display("FAIL cont_throughput got=%0d exp=15", last_cyc); end
        total++; if (if1.rdata1 !== 64'hA5) begin bad++; $display("FAIL cont_rdata1 got=%h exp=a5", if1.rdata1); end
    endtask

    task automatic test_write_m1();
        if1.req1 = 1; if1.rw1 = 1; if1.addr1 = 64'h8; if1.wdata1 = 64'h1234; if1.mask1 = 8'h0F;
        if1.bus_rdata = 64'hFFFF_0000;
        tick();
        total++; if ({if1.bus_en, if1.gnt1, if1.gnt0, if1.bus_rw} !== 4'b1101) begin bad++; $display("FAIL wr_ctrl got=%b exp=1101", {if1.bus_en, if1.gnt1, if1.gnt0, if1.bus_rw}); end
        total++; if (if1.bus_mask !== 8'h0F) begin bad++; $display("FAIL wr_mask got=%h exp=0f", if1.bus_mask); end
        total++; if ({if1.bus_addr, if1.bus_wdata} !== {64'h8, 64'h1234}) begin bad++; $display("FAIL wr_addr_data got=%h exp=8/1234", {if1.bus_addr, if1.bus_wdata}); end
        tick();
        tick();
        total++; if ({if1.ack1, if1.ack0} !== 2'b10) begin bad++; $display("FAIL wr_ack got=%b exp=10", {if1.ack1, if1.ack0}); end
        total++; if (if1.rdata1 !== 64'hA5) begin bad++; $display("FAIL wr_rdata1_hold got=%h exp=a5", if1.rdata1); end
        if1.req1 = 0; if1.rw1 = 0;
        tick();
        total++; if ({if1.ack1, if1.gnt1} !== 2'b00) begin bad++; $display("FAIL wr_after got=%b exp=00", {if1.ack1, if1.gnt1}); end
    endtask

    task automatic test_lat4();
        int   waits;
        logic got;
        logic stray;
        if4.req0 = 1; if4.rw0 = 0; if4.addr0 = 64'h200; if4.bus_rdata = 64'h4444;
        tick();
        total++; if ({if4.bus_en, if4.bus_addr} !== {1'b1, 64'h200}) begin bad++; $display("FAIL lat4_issue got=%h exp=1/200", {if4.bus_en, if4.bus_addr}); end
        waits = 0; got = 0; stray = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (if4.ack0) begin got = 1; break; end
            if (!if4.gnt0 || if4.bus_en) stray = 1;
            waits++;
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL lat4_ack_timeout got=%b exp=1", got); end
        total++; if (waits !== 4) begin bad++; $display("FAIL lat4_wait_cycles got=%0d exp=4", waits); end
        total++; if (stray !== 1'b0) begin bad++; $display("FAIL lat4_wait_ctrl got=%b exp=0", stray); end
        total++; if (if4.rdata0 !== 64'h4444) begin bad++; $display("FAIL lat4_rdata0 got=%h exp=4444", if4.rdata0); end
        if4.req0 = 0;
        tick();
        // Reset while the transaction sits in WAIT
        if4.req0 = 1; if4.addr0 = 64'h300; if4.bus_rdata = 64'h5555;
        tick(); tick(); tick();
        rst4 = 1'b1;
        #1;
        total++; if ({if4.gnt0, if4.ack0, if4.bus_en} !== 3'b000) begin bad++; $display("FAIL rst_wait_ctrl got=%b exp=000", {if4.gnt0, if4.ack0, if4.bus_en}); end
        total++; if (if4.rdata0 !== 64'h0) begin bad++; $display("FAIL rst_wait_rdata got=%h exp=0", if4.rdata0); end
        if4.req0 = 0;
        tick();
        rst4 = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (if4.ack0 || if4.gnt0) stray = 1;
        end
        total++; if (stray !== 1'b0) begin bad++; $display("FAIL rst_wait_no_ack got=%b exp=0", stray); end
        if4.req0 = 1; if4.addr0 = 64'h400; if4.bus_rdata = 64'h6666;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (if4.ack0) begin got = 1; break; end
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL post_rst_ack got=%b exp=1", got); end
        total++; if (if4.rdata0 !== 64'h6666) begin bad++; $display("FAIL post_rst_rdata got=%h exp=6666", if4.rdata0); end
        if4.req0 = 0;
        tick();
    endtask

    task automatic test_bios();
        logic got;
        logic err_seen;
        int   first;
        if1.req0 = 1; if1.rw0 = 1; if1.addr0 = 64'hFFFF_FFFF_FFFF_0010; if1.wdata0 = 64'hBAD;
        if1.bus_rdata = 64'h7777;
        tick();
`ifdef MEM_ARB_BIOS_WP_EN
        total++; if ({if1.ack0, if1.err, if1.bus_en, if1.gnt0} !== 4'b1101) begin bad++; $display("FAIL bios_reject got=%b exp=1101", {if1.ack0, if1.err, if1.bus_en, if1.gnt0}); end
        total++; if (if1.rdata0 !== 64'hA5) begin bad++; $display("FAIL bios_rdata0 got=%h exp=a5", if1.rdata0); end
        if1.req0 = 0; if1.rw0 = 0;
        tick();
        total++; if ({if1.ack0, if1.err, if1.gnt0} !== 3'b000) begin bad++; $display("FAIL bios_after got=%b exp=000", {if1.ack0, if1.err, if1.gnt0}); end
`else
        total++; if ({if1.bus_en, if1.err, if1.bus_rw} !== 3'b101) begin bad++; $display("FAIL bios_issue got=%b exp=101", {if1.bus_en, if1.err, if1.bus_rw}); end
        total++; if (if1.bus_addr !== 64'hFFFF_FFFF_FFFF_0010) begin bad++; $display("FAIL bios_addr got=%h exp=ffffffffffff0010", if1.bus_addr); end
        got = 0; err_seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (if1.err) err_seen = 1;
            if (if1.ack0) begin got = 1; break; end
        end
        total++; if ({got, err_seen} !== 2'b10) begin bad++; $display("FAIL bios_ack_err got=%b exp=10", {got, err_seen}); end
        total++; if (if1.rdata0 !== 64'hA5) begin bad++; $display("FAIL bios_wr_rdata0 got=%h exp=a5", if1.rdata0); end
        if1.req0 = 0; if1.rw0 = 0;
        tick();
`endif
        // Priority rotated away from M0 after its access
        if1.req0 = 1; if1.req1 = 1; if1.addr0 = 64'h30; if1.addr1 = 64'h40;
        first = 9;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (if1.ack0) begin first = 0; break; end
            if (if1.ack1) begin first = 1; break; end
        end
        if1.req0 = 0; if1.req1 = 0;
        tick();
        total++; if (first !== 1) begin bad++; $display("FAIL bios_prio got=M%0d exp=M1", first); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_read();
        test_contention();
        test_write_m1();
        test_lat4();
        test_bios();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
